// File: rtl/psk_pkg.sv
// -----------------------------------------------------------------------------
// psk_pkg
//
// Shared definitions for the PSK carrier address generator:
//   - psk_mode_e     : run-time modulation selector encodings
//   - gray2idx()     : Gray-coded dibit to quarter-period phase index
//   - quarter_shift(): left shift that turns a quarter-period index into a
//                      ROM address offset for a given address width
// -----------------------------------------------------------------------------
package psk_pkg;

  typedef enum logic [1:0] {
    PSK_BPSK  = 2'b00,
    PSK_DBPSK = 2'b01,
    PSK_QPSK  = 2'b10,
    PSK_DQPSK = 2'b11
  } psk_mode_e;

  // Gray dibit to phase index: 00->0, 01->1, 11->2, 10->3.
  // The MSB passes through and the LSB is the XOR of both bits.
  function automatic logic [1:0] gray2idx(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // One carrier period spans 2^addr_w ROM entries, so a quarter period is
  // 2^(addr_w-2) entries: the phase index sits in the top two address bits.
  function automatic int quarter_shift(input int addr_w);
    return addr_w - 2;
  endfunction

endpackage

// File: rtl/psk_symbol_mapper.sv
// -----------------------------------------------------------------------------
// psk_symbol_mapper
//
// Combinational symbol-to-phase mapper. Given the modulation mode, the
// incoming symbol bits and the current quarter-period phase index, produce
// the phase index to adopt when the symbol is accepted.
//
// Ports:
//   mode       in  2  modulation mode (psk_mode_e encoding)
//   sym_data   in  2  symbol bits; BPSK/DBPSK look at bit 0 only
//   phase      in  2  current quarter-period phase index
//   next_phase out 2  phase index after accepting sym_data
// -----------------------------------------------------------------------------
module psk_symbol_mapper
  import psk_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [1:0] sym_data,
  input  logic [1:0] phase,
  output logic [1:0] next_phase
);

  logic [1:0] bpsk_idx;
  logic [1:0] qpsk_idx;

  // BPSK only ever uses the half-period points 0 and 2.
  assign bpsk_idx = {sym_data[0], 1'b0};
  assign qpsk_idx = gray2idx(sym_data);

  // Differential modes add the mapped delta to the running phase; the 2-bit
  // sum wraps modulo a full period for free.
  always_comb begin
    next_phase = phase;
    case (psk_mode_e'(mode))
      PSK_BPSK:  next_phase = bpsk_idx;
      PSK_DBPSK: next_phase = phase + bpsk_idx;
      PSK_QPSK:  next_phase = qpsk_idx;
      PSK_DQPSK: next_phase = phase + qpsk_idx;
      default:   next_phase = phase;
    endcase
  end

endmodule

// File: rtl/psk_phase_addr_gen.sv
// -----------------------------------------------------------------------------
// psk_phase_addr_gen
//
// Phase-modulated carrier address generator for the DA output path. A carrier
// phase accumulator steps by CARR_STEP every enabled clock; a symbol-dependent
// quarter-period offset is added to form the registered sine-ROM address.
// Symbols are pulled from upstream at symbol boundaries through a valid/ready
// handshake; a boundary without a valid symbol holds the phase and sets a
// sticky underrun flag.
//
// Parameters:
//   ADDR_W     ROM address width, one carrier period = 2^ADDR_W entries (>= 3)
//   SYM_CYCLES enabled clocks per symbol (>= 2)
//   CARR_STEP  accumulator increment per enabled clock
//
// Ports:
//   clk         in   1       system clock, also forwarded to the converters
//   reset_n     in   1       asynchronous active-low reset
//   en          in   1       clock enable; all state holds while low
//   mode        in   2       00 BPSK, 01 DBPSK, 10 QPSK, 11 DQPSK
//   sym_valid   in   1       upstream symbol available
//   sym_data    in   2       symbol bits
//   sym_ready   out  1       boundary this cycle; symbol taken if sym_valid
//   sym_strobe  out  1       pulse on the first cycle of each symbol
//   underrun    out  1       sticky: boundary seen with sym_valid low
//   ur_clr      in   1       synchronous clear of underrun (set wins)
//   address     out  ADDR_W  registered sine-ROM address
//   clk_da      out  1       DA converter clock (= clk)
//   clk_ad      out  1       AD converter clock (= clk)
//   blank_da_n  out  1       DA blanking, held inactive
//   sync_da_n   out  1       DA sync, held inactive
// -----------------------------------------------------------------------------
module psk_phase_addr_gen
  import psk_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int SYM_CYCLES = 128,
  parameter int CARR_STEP  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              sym_valid,
  input  logic [1:0]        sym_data,
  output logic              sym_ready,
  output logic              sym_strobe,
  output logic              underrun,
  input  logic              ur_clr,
  output logic [ADDR_W-1:0] address,
  output logic              clk_da,
  output logic              clk_ad,
  output logic              blank_da_n,
  output logic              sync_da_n
);

  localparam int                CNT_W    = (SYM_CYCLES > 2) ? $clog2(SYM_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SYM_CYCLES - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(CARR_STEP);
  localparam int                QSHIFT   = quarter_shift(ADDR_W);

  logic [ADDR_W-1:0] carr_p0;
  logic [CNT_W-1:0]  sym_cnt_p0;
  logic [1:0]        phase_p0;
  logic [1:0]        phase_nxt;
  logic [ADDR_W-1:0] phase_off;
  logic              boundary;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              underrun_q;

  // Boundary is the last enabled clock of a symbol; ready is offered here
  // regardless of sym_valid so upstream can present data the same cycle.
  assign boundary  = en && (sym_cnt_p0 == CNT_LAST);
  assign sym_ready = boundary;

  psk_symbol_mapper u_mapper (
    .mode       (mode),
    .sym_data   (sym_data),
    .phase      (phase_p0),
    .next_phase (phase_nxt)
  );

  assign phase_off = ADDR_W'(phase_p0) << QSHIFT;

  // ---- stage p0: carrier accumulator, symbol counter, phase ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carr_p0    <= '0;
      sym_cnt_p0 <= '0;
      phase_p0   <= '0;
    end else if (en) begin
      carr_p0 <= carr_p0 + STEP;
      if (boundary) begin
        sym_cnt_p0 <= '0;
        // An underrun leaves the phase untouched: a zero delta in the
        // differential modes and a repeated point in the coherent ones.
        if (sym_valid) begin
          phase_p0 <= phase_nxt;
        end
      end else begin
        sym_cnt_p0 <= sym_cnt_p0 + 1'b1;
      end
    end
  end

  // ---- stage p1: registered ROM address and symbol-start strobe ----
  // The address is built from the phase already held in p0, so a symbol
  // accepted on one edge reaches the address on the following edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (en) begin
      addr_p1 <= carr_p0 + phase_off;
      vld_p1  <= boundary;
    end
  end

  // Sticky underrun. The clear is ordered before the set so that a new
  // underrun in the same cycle as ur_clr is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_q <= 1'b0;
    end else begin
      if (ur_clr) begin
        underrun_q <= 1'b0;
      end
      if (boundary && !sym_valid) begin
        underrun_q <= 1'b1;
      end
    end
  end

  assign address    = addr_p1;
  assign sym_strobe = vld_p1;
  assign underrun   = underrun_q;

  assign clk_da     = clk;
  assign clk_ad     = clk;
  assign blank_da_n = 1'b1;
  assign sync_da_n  = 1'b1;

endmodule
